rf_op_sequencer: RTL and testbench

- Initiator side of the register-file port: accepts one ALU-style operation per handshake and sequences it against an external register file.
- Per operation: drive read addresses, capture the operands, compute, issue a single write-back, then report completion.
- Sits between the instruction/control path and the register file. Drives that file's read-select, write-select, write-enable and write-data inputs, and consumes its two read-data outputs.

---
 rtl/rf_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_rf_op_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_op_sequencer.sv
// Register-file operation sequencer: accepts one ALU op, reads operands, computes, writes back, signals done.
// Optional status flags (flag_zero, flag_carry) enabled with the RFSEQ_FLAGS_EN macro.
module rf_op_sequencer #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    op_code,
  input  logic [AW-1:0] op_rd,
  input  logic [AW-1:0] op_rs,
  input  logic [DW-1:0] op_imm,
  output logic [AW-1:0] rf_read_reg,
  output logic [AW-1:0] rf_write_reg,
  output logic          rf_write_en,
  output logic [DW-1:0] rf_write_data,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          done_valid,
  output logic [DW-1:0] done_result,
  output logic          busy
`ifdef RFSEQ_FLAGS_EN
  ,
  output logic          flag_zero,
  output logic          flag_carry
`endif
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_LOADI = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    code_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] alu_res_c;
  logic          accept_c;

  assign accept_c = (state == S_IDLE) && op_valid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: fixed one-cycle walk through the non-idle states
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept_c) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ALU result, truncated to DW bits
  always_comb begin
    alu_res_c = '0;
    case (code_q)
      OP_ADD:   alu_res_c = a_q + b_q;
      OP_SUB:   alu_res_c = a_q - b_q;
      OP_AND:   alu_res_c = a_q & b_q;
      OP_LOADI: alu_res_c = imm_q;
      default:  alu_res_c = '0;
    endcase
  end

`ifdef RFSEQ_FLAGS_EN
  logic [DW:0] sum_c;
  logic        carry_c;

  // Carry for ADD is the bit above the result; for SUB it is the unsigned borrow
  always_comb begin
    sum_c   = {1'b0, a_q} + {1'b0, b_q};
    carry_c = 1'b0;
    case (code_q)
      OP_ADD:  carry_c = sum_c[DW];
      OP_SUB:  carry_c = (a_q < b_q);
      default: carry_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (state == S_EXEC) begin
      flag_zero  <= (alu_res_c == '0);
      flag_carry <= carry_c;
    end
  end
`endif

  // Registered outputs and datapath; strobes are decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      op_ready      <= 1'b1;
      busy          <= 1'b0;
      rf_write_en   <= 1'b0;
      done_valid    <= 1'b0;
      rf_read_reg   <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      done_result   <= '0;
      code_q        <= '0;
      imm_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      op_ready    <= (state_next == S_IDLE);
      busy        <= (state_next != S_IDLE);
      rf_write_en <= (state_next == S_WRITE);
      done_valid  <= (state_next == S_DONE);
      if (accept_c) begin
        code_q       <= op_code;
        imm_q        <= op_imm;
        rf_write_reg <= op_rd;
        rf_read_reg  <= op_rs;
      end
      if (state == S_READ) begin
        a_q <= rf_rdata1;
        b_q <= rf_rdata2;
      end
      if (state == S_EXEC)  rf_write_data <= alu_res_c;
      if (state == S_WRITE) done_result   <= rf_write_data;
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Self-checking bench for rf_op_sequencer: directed and random ops against a small register-file model.
// Flag checks are compiled in when RFSEQ_FLAGS_EN is defined.
module tb_rf_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [0:0] op_rd;
  logic [0:0] op_rs;
  logic [7:0] op_imm;
  logic [0:0] rf_read_reg;
  logic [0:0] rf_write_reg;
  logic       rf_write_en;
  logic [7:0] rf_write_data;
  logic [7:0] rf_rdata1;
  logic [7:0] rf_rdata2;
  logic       done_valid;
  logic [7:0] done_result;
  logic       busy;
`ifdef RFSEQ_FLAGS_EN
  logic       flag_zero;
  logic       flag_carry;
`endif

  logic [7:0] rf_mem [2];
  logic [7:0] exp_rf [2];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  rf_op_sequencer #(.DW(8), .AW(1)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_rd(op_rd), .op_rs(op_rs), .op_imm(op_imm),
    .rf_read_reg(rf_read_reg), .rf_write_reg(rf_write_reg),
    .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .done_valid(done_valid), .done_result(done_result), .busy(busy)
`ifdef RFSEQ_FLAGS_EN
    , .flag_zero(flag_zero), .flag_carry(flag_carry)
`endif
  );

  // External register file model: combinational reads, write on rising edge
  assign rf_rdata1 = rf_mem[rf_write_reg];
  assign rf_rdata2 = rf_mem[rf_read_reg];

  always @(posedge clk) begin
    if (rf_write_en) begin
      rf_mem[rf_write_reg] = rf_write_data;
      wr_cnt = wr_cnt + 1;
    end
    if (done_valid) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_res(input int c, input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] imm);
    int s;
    case (c)
      0: s = (int'(a) + int'(b)) % 256;
      1: s = (int'(a) - int'(b) + 256) % 256;
      2: s = int'(a & b);
      default: s = int'(imm);
    endcase
    return 8'(s);
  endfunction

`ifdef RFSEQ_FLAGS_EN
  function automatic logic model_carry(input int c, input logic [7:0] a, input logic [7:0] b);
    if (c == 0) return (int'(a) + int'(b)) > 255;
    if (c == 1) return int'(a) < int'(b);
    return 1'b0;
  endfunction
`endif

  task automatic preset(input logic [7:0] r0, input logic [7:0] r1);
    @(negedge clk);
    rf_mem[0] = r0; rf_mem[1] = r1;
    exp_rf[0] = r0; exp_rf[1] = r1;
  endtask

  // One op from IDLE; cycle k counts periods after the accept edge (1=READ .. 4=DONE)
  task automatic do_op(input int c, input int rd, input int rs, input logic [7:0] imm, input bit noise);
    logic [7:0] r;
    int n;
    int wr0;
    int dn0;
    r = model_res(c, exp_rf[rd], exp_rf[rs], imm);
    @(negedge clk);
    n = 0;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ready_timeout", 0, 1);
    op_valid = 1'b1; op_code = 2'(c); op_rd = 1'(rd); op_rs = 1'(rs); op_imm = imm;
    wr0 = wr_cnt; dn0 = done_cnt;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      op_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op_code = 2'($urandom_range(0, 3)); op_rd = 1'($urandom_range(0, 1));
      op_rs = 1'($urandom_range(0, 1)); op_imm = 8'($urandom);
      chk("ready_busy", 32'(op_ready), 0);
      chk("busy", 32'(busy), 1);
      chk("wen", 32'(rf_write_en), 32'(k == 3));
      chk("dv", 32'(done_valid), 32'(k == 4));
      chk("wr_reg", 32'(rf_write_reg), 32'(rd));
      chk("rd_reg", 32'(rf_read_reg), 32'(rs));
      if (k == 3) chk("wdata", 32'(rf_write_data), 32'(r));
      if (k == 4) begin
        chk("dres", 32'(done_result), 32'(r));
        chk("dres_zero", 32'(done_result == 8'h00), 32'(r == 8'h00));
      end
`ifdef RFSEQ_FLAGS_EN
      if (k >= 3) begin
        chk("flag_zero", 32'(flag_zero), 32'(r == 8'h00));
        chk("flag_carry", 32'(flag_carry), 32'(model_carry(c, exp_rf[rd], exp_rf[rs])));
      end
`endif
    end
    @(negedge clk);
    op_valid = 1'b0;
    chk("idle_ready", 32'(op_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("wr_pulses", 32'(wr_cnt - wr0), 1);
    chk("done_pulses", 32'(done_cnt - dn0), 1);
    chk("dres_hold", 32'(done_result), 32'(r));
    exp_rf[rd] = r;
    chk("rf_content", 32'(rf_mem[rd]), 32'(r));
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 32'(op_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wen", 32'(rf_write_en), 0);
    chk("rst_dv", 32'(done_valid), 0);
    chk("rst_rreg", 32'(rf_read_reg), 0);
    chk("rst_wreg", 32'(rf_write_reg), 0);
    chk("rst_wdata", 32'(rf_write_data), 0);
    chk("rst_dres", 32'(done_result), 0);
`ifdef RFSEQ_FLAGS_EN
    chk("rst_fz", 32'(flag_zero), 0);
    chk("rst_fc", 32'(flag_carry), 0);
`endif
  endtask

  typedef struct {
    int c;
    int rd;
    int rs;
    logic [7:0] imm;
  } op_t;

  initial begin
    op_t q[$];
    op_t o;
    int accepts;
    int wr0;
    logic [7:0] r;
    logic acc;

    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_rd = '0; op_rs = '0; op_imm = '0;
    rf_mem[0] = 8'd2; rf_mem[1] = 8'd4; exp_rf[0] = 8'd2; exp_rf[1] = 8'd4;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Directed cases
    preset(8'd2, 8'd4); do_op(0, 0, 1, 8'h00, 1'b0);
    preset(8'd2, 8'd4); do_op(1, 0, 1, 8'h00, 1'b0);
    chk("sub_r0", 32'(rf_mem[0]), 32'h0FE);
    do_op(3, 1, 0, 8'hFF, 1'b0);
    do_op(0, 1, 1, 8'h00, 1'b0);
    chk("loadi_add_r1", 32'(rf_mem[1]), 32'h0FE);
    preset(8'd2, 8'd4); do_op(2, 0, 1, 8'h00, 1'b0);
    chk("and_r0", 32'(rf_mem[0]), 32'h000);

    // op_valid held high with three queued ops: one accept per five cycles
    preset(8'd7, 8'd250);
    q.push_back('{c: 0, rd: 0, rs: 1, imm: 8'h00});
    q.push_back('{c: 1, rd: 1, rs: 0, imm: 8'h00});
    q.push_back('{c: 3, rd: 0, rs: 0, imm: 8'h5A});
    foreach (q[i]) begin
      r = model_res(q[i].c, exp_rf[q[i].rd], exp_rf[q[i].rs], q[i].imm);
      exp_rf[q[i].rd] = r;
    end
    accepts = 0; wr0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      op_valid = (q.size() > 0);
      if (q.size() > 0) begin
        o = q[0];
        op_code = 2'(o.c); op_rd = 1'(o.rd); op_rs = 1'(o.rs); op_imm = o.imm;
      end
      chk("stream_ready", 32'(op_ready), 32'((i % 5 == 0) || i >= 15));
      acc = op_valid && op_ready;
      if (acc) begin void'(q.pop_front()); accepts++; end
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("stream_accepts", 32'(accepts), 3);
    chk("stream_writes", 32'(wr_cnt - wr0), 3);
    chk("stream_r0", 32'(rf_mem[0]), 32'(exp_rf[0]));
    chk("stream_r1", 32'(rf_mem[1]), 32'(exp_rf[1]));

    // Reset during EXEC aborts the op with no write and no completion
    preset(8'd2, 8'd4);
    op_valid = 1'b1; op_code = 2'b00; op_rd = 1'b0; op_rs = 1'b1;
    @(negedge clk); op_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    wr0 = wr_cnt; accepts = done_cnt;
    @(negedge clk); reset = 1'b0;
    check_reset_outputs();
    repeat (6) @(negedge clk);
    chk("abort_writes", 32'(wr_cnt - wr0), 0);
    chk("abort_done", 32'(done_cnt - accepts), 0);
    chk("abort_r0", 32'(rf_mem[0]), 2);

    // Randomized ops with noise on op_valid while busy
    for (int i = 0; i < 25; i++)
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            8'($urandom), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
